// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared widths, state codes and coin helper for the vending sequencer
package vending_pkg;

    localparam int CREDIT_W = 4;
    localparam int PRICE_W  = 3;
    localparam int COIN_W   = 2;
    localparam int KEY_W    = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_COL = 3'd1,
        S_LOOKUP   = 3'd2,
        S_PAY      = 3'd3,
        S_DISPENSE = 3'd4,
        S_REFUND   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    // True when adding the coin keeps the credit within the register range.
    function automatic logic coin_fits(input logic [CREDIT_W-1:0] credit,
                                       input logic [COIN_W-1:0]   value);
        return ({1'b0, credit} + (CREDIT_W+1)'(value)) <= (CREDIT_W+1)'((1 << CREDIT_W) - 1);
    endfunction

endpackage

// File: rtl/vending_if.sv
// rtl/vending_if.sv - keypad/coin/selector/display bundle around the sequencer
interface vending_if;
    import vending_pkg::*;

    logic                tick_1hz;
    logic                key_valid;
    logic [KEY_W-1:0]    key_code;
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_value;
    logic                cancel;
    logic                prod_exists;
    logic [PRICE_W-1:0]  prod_price;
    logic [KEY_W-1:0]    sel_row;
    logic [KEY_W-1:0]    sel_col;
    logic                sel_en;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] change;
    logic                dispense;
    logic                refund;
    logic                coin_reject;
    logic [2:0]          state;

    modport master (
        input  tick_1hz, key_valid, key_code, coin_valid, coin_value, cancel,
               prod_exists, prod_price,
        output sel_row, sel_col, sel_en, credit, change, dispense, refund,
               coin_reject, state
    );

    modport slave (
        output tick_1hz, key_valid, key_code, coin_valid, coin_value, cancel,
               prod_exists, prod_price,
        input  sel_row, sel_col, sel_en, credit, change, dispense, refund,
               coin_reject, state
    );

endinterface

// File: rtl/contador_segundos.sv
// rtl/contador_segundos.sv - clearable saturating seconds counter advanced by tick_1hz
module contador_segundos #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_i,
    input  logic          tick_i,
    output logic [TW-1:0] count_o
);

    logic [TW-1:0] count_q, count_d;

    // Clear wins over a same-clk tick so the entry tick is dropped.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != {TW{1'b1}})) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sequenciador_venda.sv
// rtl/sequenciador_venda.sv - vending transaction sequencer: key capture, lookup, payment, dispense/refund
module sequenciador_venda
    import vending_pkg::*;
#(
    parameter int DIG_TIMEOUT = 15,
    parameter int PAY_TIMEOUT = 15,
    parameter int HOLD_TIME   = 5,
    parameter int TW          = 4
) (
    input logic       clk,
    input logic       reset_n,
    vending_if.master bus
);

    localparam logic [TW-1:0] DIG_T  = TW'(DIG_TIMEOUT);
    localparam logic [TW-1:0] PAY_T  = TW'(PAY_TIMEOUT);
    localparam logic [TW-1:0] HOLD_T = TW'(HOLD_TIME);

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    row_q, row_d, col_q, col_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, change_q, change_d;
    logic [PRICE_W-1:0]  price_q, price_d;
    logic                reject_q, reject_d;
    logic                coin_took;
    logic                timer_clr;
    logic [TW-1:0]       timer;

    contador_segundos #(.TW(TW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (timer_clr),
        .tick_i  (bus.tick_1hz),
        .count_o (timer)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            credit_q <= '0;
            change_q <= '0;
            price_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            credit_q <= credit_d;
            change_q <= change_d;
            price_q  <= price_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        credit_d  = credit_q;
        change_d  = change_q;
        price_d   = price_q;
        coin_took = 1'b0;
        case (state_q)
            S_IDLE: begin
                credit_d = '0;
                if (bus.key_valid) begin
                    row_d   = bus.key_code;
                    state_d = S_WAIT_COL;
                end
            end
            S_WAIT_COL: begin
                if (bus.key_valid) begin
                    col_d   = bus.key_code;
                    state_d = S_LOOKUP;
                end else if (timer == DIG_T) begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (bus.prod_exists) begin
                    price_d = bus.prod_price;
                    state_d = S_PAY;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_PAY: begin
                // Paid decision uses the registered credit; a coin on that clk is turned away.
                if (credit_q >= CREDIT_W'(price_q)) begin
                    state_d  = S_DISPENSE;
                    change_d = credit_q - CREDIT_W'(price_q);
                end else begin
                    coin_took = bus.coin_valid && (bus.coin_value != '0)
                                && coin_fits(credit_q, bus.coin_value);
                    if (coin_took) begin
                        credit_d = credit_q + CREDIT_W'(bus.coin_value);
                    end
                    if (bus.cancel) begin
                        state_d = (credit_d != '0) ? S_REFUND : S_IDLE;
                    end else if (!coin_took && (timer == PAY_T)) begin
                        state_d = (credit_q != '0) ? S_REFUND : S_IDLE;
                    end
                end
            end
            S_DISPENSE, S_REFUND, S_ERROR: begin
                if (timer == HOLD_T) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every return to IDLE leaves a clean transaction context behind.
        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            row_d    = '0;
            col_d    = '0;
            credit_d = '0;
            change_d = '0;
            price_d  = '0;
        end
    end

    assign reject_d  = bus.coin_valid && !coin_took;
    assign timer_clr = coin_took || (state_d != state_q);

    always_comb begin
        bus.state       = state_q;
        bus.sel_row     = row_q;
        bus.sel_col     = col_q;
        bus.credit      = credit_q;
        bus.change      = change_q;
        bus.coin_reject = reject_q;
        bus.sel_en      = (state_q == S_LOOKUP) || (state_q == S_PAY) || (state_q == S_DISPENSE);
        bus.dispense    = (state_q == S_DISPENSE);
        bus.refund      = (state_q == S_REFUND);
    end

endmodule

// File: tb/tb_sequenciador_venda.sv
// tb/tb_sequenciador_venda.sv - self-checking bench for sequenciador_venda
module tb_sequenciador_venda;

    localparam int DIG_T  = 15;
    localparam int PAY_T  = 15;
    localparam int HOLD_T = 5;
    localparam int SEC_MAX = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    // Transaction-level model state: phase number, latched keys, money in units, seconds since entry.
    int m_state = 0, m_row = 0, m_col = 0, m_credit = 0, m_price = 0, m_change = 0, m_secs = 0, m_rej = 0;

    vending_if bus();

    sequenciador_venda #(
        .DIG_TIMEOUT (DIG_T),
        .PAY_TIMEOUT (PAY_T),
        .HOLD_TIME   (HOLD_T),
        .TW          (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_row = 0; m_col = 0; m_credit = 0;
        m_price = 0; m_change = 0; m_secs = 0; m_rej = 0;
    endtask

    task automatic model_step();
        int  nxt;
        bit  paid_in;
        int  coin;
        nxt     = m_state;
        paid_in = 1'b0;
        coin    = int'(bus.coin_value);
        if (m_state == 0) begin
            if (bus.key_valid) begin m_row = int'(bus.key_code); nxt = 1; end
        end else if (m_state == 1) begin
            if (bus.key_valid) begin m_col = int'(bus.key_code); nxt = 2; end
            else if (m_secs == DIG_T) nxt = 0;
        end else if (m_state == 2) begin
            if (bus.prod_exists) begin m_price = int'(bus.prod_price); nxt = 3; end
            else nxt = 6;
        end else if (m_state == 3) begin
            if (m_credit >= m_price) begin
                m_change = m_credit - m_price;
                nxt = 4;
            end else begin
                if (bus.coin_valid && coin > 0 && m_credit + coin <= 15) begin
                    m_credit += coin;
                    paid_in = 1'b1;
                end
                if (bus.cancel) nxt = (m_credit > 0) ? 5 : 0;
                else if (!paid_in && m_secs == PAY_T) nxt = (m_credit > 0) ? 5 : 0;
            end
        end else begin
            if (m_secs == HOLD_T) nxt = 0;
        end
        m_rej = (bus.coin_valid && !paid_in) ? 1 : 0;
        if (nxt == 0 && m_state != 0) begin
            m_row = 0; m_col = 0; m_credit = 0; m_price = 0; m_change = 0;
        end
        if (nxt != m_state || paid_in) m_secs = 0;
        else if (bus.tick_1hz && m_secs < SEC_MAX) m_secs++;
        m_state = nxt;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state",       int'(bus.state),       m_state);
            chk("credit",      int'(bus.credit),      m_credit);
            chk("sel_row",     int'(bus.sel_row),     m_row);
            chk("sel_col",     int'(bus.sel_col),     m_col);
            chk("change",      int'(bus.change),      m_change);
            chk("sel_en",      int'(bus.sel_en),      (m_state >= 2 && m_state <= 4) ? 1 : 0);
            chk("dispense",    int'(bus.dispense),    (m_state == 4) ? 1 : 0);
            chk("refund",      int'(bus.refund),      (m_state == 5) ? 1 : 0);
            chk("coin_reject", int'(bus.coin_reject), m_rej);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input int code);
        bus.key_valid = 1'b1;
        bus.key_code  = 2'(code);
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic coin(input int value);
        bus.coin_valid = 1'b1;
        bus.coin_value = 2'(value);
        cyc();
        bus.coin_valid = 1'b0;
        bus.coin_value = 2'd0;
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic select(input int r, input int c, input bit exists, input int price);
        bus.prod_exists = exists;
        bus.prod_price  = 3'(price);
        press(r);
        press(c);
        cyc();
    endtask

    task automatic hold_exit();
        repeat (HOLD_T) tick();
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.tick_1hz = 1'b0; bus.key_valid = 1'b0; bus.key_code = 2'd0;
        bus.coin_valid = 1'b0; bus.coin_value = 2'd0; bus.cancel = 1'b0;
        bus.prod_exists = 1'b0; bus.prod_price = 3'd0;
        repeat (3) cyc();
        chk("rst_state",  int'(bus.state), 0);
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_outs",   int'({bus.sel_en, bus.dispense, bus.refund, bus.coin_reject}), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Normal purchase: price 3, coins 2+2, change 1
        select(2, 1, 1'b1, 3);
        chk("t1_pay", int'(bus.state), 3);
        chk("t1_keys", int'({bus.sel_row, bus.sel_col}), 9);
        coin(2);
        coin(2);
        chk("t1_credit", int'(bus.credit), 4);
        chk("t1_no_disp_yet", int'(bus.dispense), 0);
        cyc();
        chk("t1_dispense", int'(bus.dispense), 1);
        chk("t1_change", int'(bus.change), 1);
        repeat (HOLD_T) tick();
        chk("t1_held", int'(bus.dispense), 1);
        cyc();
        chk("t1_idle", int'(bus.state), 0);
        chk("t1_credit0", int'(bus.credit), 0);

        // Missing product
        select(0, 3, 1'b0, 0);
        chk("t2_error", int'(bus.state), 6);
        chk("t2_flags", int'({bus.dispense, bus.refund}), 0);
        repeat (HOLD_T) tick();
        chk("t2_held", int'(bus.state), 6);
        cyc();
        chk("t2_idle", int'(bus.state), 0);

        // Payment timeout with and without credit
        select(1, 1, 1'b1, 5);
        coin(1);
        repeat (PAY_T) tick();
        chk("t3_still_pay", int'(bus.state), 3);
        cyc();
        chk("t3_refund", int'(bus.refund), 1);
        chk("t3_credit", int'(bus.credit), 1);
        hold_exit();
        chk("t3_idle", int'(bus.state), 0);
        select(1, 1, 1'b1, 5);
        repeat (PAY_T) tick();
        cyc();
        chk("t3b_idle", int'(bus.state), 0);
        chk("t3b_refund", int'(bus.refund), 0);

        // Rejected coins
        select(3, 2, 1'b1, 7);
        coin(3);
        coin(3);
        coin(0);
        chk("t4_reject", int'(bus.coin_reject), 1);
        chk("t4_credit", int'(bus.credit), 6);
        cyc();
        chk("t4_reject_pulse", int'(bus.coin_reject), 0);
        bus.cancel = 1'b1;
        cyc();
        bus.cancel = 1'b0;
        chk("t4_cancel_refund", int'(bus.state), 5);
        hold_exit();
        coin(2);
        chk("t4_idle_reject", int'(bus.coin_reject), 1);
        chk("t4_idle_credit", int'(bus.credit), 0);

        // Coin races against cancel and timeout
        select(1, 2, 1'b1, 7);
        coin(1);
        coin(1);
        bus.cancel = 1'b1;
        coin(1);
        bus.cancel = 1'b0;
        chk("t5_credit", int'(bus.credit), 3);
        chk("t5_refund", int'(bus.state), 5);
        hold_exit();
        select(1, 2, 1'b1, 7);
        coin(1);
        repeat (PAY_T) tick();
        coin(1);
        chk("t5_stay_pay", int'(bus.state), 3);
        chk("t5b_credit", int'(bus.credit), 2);
        bus.cancel = 1'b1;
        cyc();
        bus.cancel = 1'b0;
        hold_exit();

        // Free product then asynchronous reset during dispense
        select(0, 0, 1'b1, 0);
        cyc();
        chk("t6_dispense", int'(bus.state), 4);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_state", int'(bus.state), 0);
        chk("t6_rst_outs", int'({bus.dispense, bus.refund, bus.sel_en, bus.sel_row, bus.sel_col}), 0);
        chk("t6_rst_credit", int'(bus.credit), 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Column timeout; the tick on the entry clk is dropped
        bus.tick_1hz = 1'b1;
        press(3);
        bus.tick_1hz = 1'b0;
        chk("t6_wait_col", int'(bus.state), 1);
        chk("t6_row", int'(bus.sel_row), 3);
        repeat (DIG_T) tick();
        chk("t6_no_early_abort", int'(bus.state), 1);
        cyc();
        chk("t6_col_timeout", int'(bus.state), 0);
        chk("t6_row_clear", int'(bus.sel_row), 0);

        cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
